// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV64 control sequencer: opcodes, ALU ops, state codes.
package multicycle_control_pkg;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_WB_R   = 4'd4;
    localparam logic [3:0] ST_ADDR   = 4'd5;
    localparam logic [3:0] ST_MEM_RD = 4'd6;
    localparam logic [3:0] ST_WB_LD  = 4'd7;
    localparam logic [3:0] ST_MEM_WR = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_TRAP   = 4'd10;

    // States that hold a memory request until mem_ready.
    function automatic logic isWaitState(input logic [3:0] st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles spent waiting on the shared memory port; flags the cycle that would hit the limit.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // Asserted on the waiting cycle whose miss would bring the count to MEM_TIMEOUT.
    assign expired = tick && (count == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: walks R-format, ld, sd and beq through FETCH..WB and drives datapath enables.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Opc,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IorD,
    output logic             IRWrite,
    output logic             ALUsrc,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [1:0]       AluOp,
    output logic             Illegal,
    output logic             MemErr,
    output logic [CNT_W-1:0] instr_count
);
    import multicycle_control_pkg::*;

    logic [3:0]       state;
    logic [3:0]       stateNext;
    logic [6:0]       opcReg;
    logic             illegalReg;
    logic             memErrReg;
    logic [CNT_W-1:0] instrCount;
    logic             setIllegal;
    logic             setMemErr;
    logic             retire;
    logic             waitExpired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (stateNext != state),
        .tick   (isWaitState(state) && !mem_ready),
        .expired(waitExpired)
    );

    always_comb begin
        stateNext  = state;
        setIllegal = 1'b0;
        setMemErr  = 1'b0;
        case (state)
            ST_RST:    stateNext = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    stateNext = ST_DECODE;
                end else if (waitExpired) begin
                    stateNext = ST_TRAP;
                    setMemErr = 1'b1;
                end
            end
            ST_DECODE: begin
                case (Opc)
                    OPC_R:          stateNext = ST_EXEC_R;
                    OPC_LD, OPC_SD: stateNext = ST_ADDR;
                    OPC_BEQ:        stateNext = ST_BRANCH;
                    default: begin
                        stateNext  = ST_TRAP;
                        setIllegal = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R: stateNext = ST_WB_R;
            ST_WB_R:   stateNext = ST_FETCH;
            ST_ADDR:   stateNext = (opcReg == OPC_SD) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ready) begin
                    stateNext = (state == ST_MEM_RD) ? ST_WB_LD : ST_FETCH;
                end else if (waitExpired) begin
                    stateNext = ST_TRAP;
                    setMemErr = 1'b1;
                end
            end
            ST_WB_LD:  stateNext = ST_FETCH;
            ST_BRANCH: stateNext = ST_FETCH;
            ST_TRAP:   stateNext = ST_TRAP;
            default:   stateNext = ST_RST;
        endcase
    end

    assign retire = (state == ST_WB_R) || (state == ST_WB_LD) || (state == ST_BRANCH) ||
                    ((state == ST_MEM_WR) && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RST;
            opcReg     <= '0;
            illegalReg <= 1'b0;
            memErrReg  <= 1'b0;
            instrCount <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_DECODE) begin
                opcReg <= Opc;
            end
            if (setIllegal) begin
                illegalReg <= 1'b1;
            end
            if (setMemErr) begin
                memErrReg <= 1'b1;
            end
            if (retire) begin
                instrCount <= instrCount + 1'b1;
            end
        end
    end

    // Outputs are forced low while rst is high so a reset mid-access issues no write.
    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        ALUsrc   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        AluOp    = ALUOP_ADD;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_EXEC_R: AluOp = ALUOP_FUNCT;
                ST_WB_R: begin
                    AluOp    = ALUOP_FUNCT;
                    RegWrite = 1'b1;
                end
                ST_ADDR:   ALUsrc = 1'b1;
                ST_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_WB_LD: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                ST_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    ALUsrc   = 1'b1;
                end
                ST_BRANCH: begin
                    AluOp   = ALUOP_SUB;
                    Branch  = 1'b1;
                    PCSrc   = 1'b1;
                    PCWrite = Zero;
                end
                default: ;
            endcase
        end
    end

    assign Illegal     = !rst && illegalReg;
    assign MemErr      = !rst && memErrReg;
    assign instr_count = rst ? '0 : instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level step-queue model.
module tb_multicycle_control;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] SD_OP  = 7'b0100011;
    localparam logic [6:0] BEQ_OP = 7'b1100011;

    // Step names for the model's per-instruction work list.
    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_EXECR = 3, S_WBR = 4, S_ADDR = 5;
    localparam int S_MEMRD = 6, S_WBLD = 7, S_MEMWR = 8, S_BRANCH = 9, S_TRAP = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       Opc = '0;
    logic             Zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCSrc, IorD, IRWrite, ALUsrc, MemToReg, RegWrite;
    logic             MemRead, MemWrite, Branch, Illegal, MemErr;
    logic [1:0]       AluOp;
    logic [CNT_W-1:0] instr_count;
    logic [11:0]      ctrlVec;

    int checks = 0;
    int fails  = 0;

    int q[$];
    int waitCnt = 0;
    bit mIll = 1'b0;
    bit mErr = 1'b0;
    int mCnt = 0;

    multicycle_control #(
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Opc        (Opc),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .ALUsrc     (ALUsrc),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .AluOp      (AluOp),
        .Illegal    (Illegal),
        .MemErr     (MemErr),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctrlVec = {PCWrite, PCSrc, IorD, IRWrite, ALUsrc, MemToReg, RegWrite,
                      MemRead, MemWrite, Branch, AluOp};

    // {PCWrite,PCSrc,IorD,IRWrite,ALUsrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,AluOp[1:0]}
    function automatic logic [11:0] expOuts(input int s, input logic m, input logic z);
        case (s)
            S_FETCH:  return {m, 1'b0, 1'b0, m, 8'b0001_0000};
            S_EXECR:  return 12'b0000_0000_0010;
            S_WBR:    return 12'b0000_0010_0010;
            S_ADDR:   return 12'b0000_1000_0000;
            S_MEMRD:  return 12'b0010_0001_0000;
            S_WBLD:   return 12'b0000_0110_0000;
            S_MEMWR:  return 12'b0010_1000_1000;
            S_BRANCH: return {z, 11'b100_0000_0101};
            default:  return 12'b0;
        endcase
    endfunction

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic waitMiss();
        waitCnt++;
        if (waitCnt >= TIMEOUT) begin
            q.delete();
            q.push_back(S_TRAP);
            mErr    = 1'b1;
            waitCnt = 0;
        end
    endtask

    task automatic popStep();
        void'(q.pop_front());
        waitCnt = 0;
    endtask

    // One clock: drive inputs, compare every output against the model, then advance the model.
    task automatic step(input logic r, input logic [6:0] o, input logic z, input logic m);
        int               head;
        logic [11:0]      expCtrl;
        logic [1:0]       expFlags;
        logic [CNT_W-1:0] expCnt;
        @(negedge clk);
        rst       = r;
        Opc       = o;
        Zero      = z;
        mem_ready = m;
        #1;
        head = (q.size() > 0) ? q[0] : S_TRAP;
        if (r) begin
            expCtrl  = '0;
            expFlags = '0;
            expCnt   = '0;
        end else begin
            expCtrl  = expOuts(head, m, z);
            expFlags = {mIll, mErr};
            expCnt   = mCnt[CNT_W-1:0];
        end
        checkEq("ctrl", {20'b0, ctrlVec}, {20'b0, expCtrl});
        checkEq("flags", {30'b0, Illegal, MemErr}, {30'b0, expFlags});
        checkEq("count", {{(32-CNT_W){1'b0}}, instr_count}, {{(32-CNT_W){1'b0}}, expCnt});
        if (r) begin
            q.delete();
            q.push_back(S_RST);
            waitCnt = 0;
            mIll    = 1'b0;
            mErr    = 1'b0;
            mCnt    = 0;
        end else begin
            case (head)
                S_RST:   popStep();
                S_FETCH: begin
                    if (m) begin
                        popStep();
                        q.push_back(S_DECODE);
                    end else begin
                        waitMiss();
                    end
                end
                S_DECODE: begin
                    popStep();
                    case (o)
                        R_OP:    begin q.push_back(S_EXECR); q.push_back(S_WBR); end
                        LD_OP:   begin q.push_back(S_ADDR); q.push_back(S_MEMRD); q.push_back(S_WBLD); end
                        SD_OP:   begin q.push_back(S_ADDR); q.push_back(S_MEMWR); end
                        BEQ_OP:  q.push_back(S_BRANCH);
                        default: begin q.push_back(S_TRAP); mIll = 1'b1; end
                    endcase
                end
                S_MEMRD: if (m) popStep(); else waitMiss();
                S_MEMWR: begin
                    if (m) begin
                        popStep();
                        mCnt++;
                    end else begin
                        waitMiss();
                    end
                end
                S_TRAP: ;
                S_WBR, S_WBLD, S_BRANCH: begin
                    popStep();
                    mCnt++;
                end
                default: popStep();
            endcase
            if (q.size() == 0) q.push_back(S_FETCH);
        end
    endtask

    initial begin
        logic [6:0] opcs [4];
        int         readyPct;
        opcs[0] = R_OP;
        opcs[1] = LD_OP;
        opcs[2] = SD_OP;
        opcs[3] = BEQ_OP;

        // Reset and one R-format with immediate memory.
        step(1, 7'd0, 0, 0);
        step(1, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);
        checkEq("rst_release_ctrl", {20'b0, ctrlVec}, 32'h0);
        checkEq("rst_release_cnt", {24'b0, instr_count}, 32'h0);
        step(0, 7'd0, 0, 1);
        checkEq("fetch_ready_ctrl", {20'b0, ctrlVec}, 32'h910);
        step(0, R_OP, 0, 1);
        checkEq("decode_ctrl", {20'b0, ctrlVec}, 32'h0);
        step(0, 7'd0, 0, 1);
        checkEq("exec_r_ctrl", {20'b0, ctrlVec}, 32'h002);
        step(0, 7'd0, 0, 1);
        checkEq("wb_r_ctrl", {20'b0, ctrlVec}, 32'h022);
        step(0, 7'd0, 0, 0);
        checkEq("fetch_wait_ctrl", {20'b0, ctrlVec}, 32'h010);
        checkEq("r_retired_cnt", {24'b0, instr_count}, 32'h1);

        // ld with a 3-cycle data wait.
        step(0, 7'd0, 0, 1);
        step(0, LD_OP, 0, 0);
        step(0, 7'd0, 0, 1);
        checkEq("addr_ctrl", {20'b0, ctrlVec}, 32'h080);
        step(0, 7'd0, 0, 0);
        checkEq("mem_rd_wait1", {20'b0, ctrlVec}, 32'h210);
        step(0, 7'd0, 0, 0);
        checkEq("mem_rd_wait2", {20'b0, ctrlVec}, 32'h210);
        step(0, 7'd0, 0, 1);
        checkEq("mem_rd_done", {20'b0, ctrlVec}, 32'h210);
        step(0, 7'd0, 0, 1);
        checkEq("wb_ld_ctrl", {20'b0, ctrlVec}, 32'h060);

        // sd, then two beq (taken, not taken).
        step(0, 7'd0, 0, 1);
        checkEq("ld_retired_cnt", {24'b0, instr_count}, 32'h2);
        step(0, SD_OP, 0, 1);
        step(0, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);
        checkEq("mem_wr_ctrl", {20'b0, ctrlVec}, 32'h288);
        step(0, 7'd0, 0, 1);
        checkEq("after_sd_ctrl", {20'b0, ctrlVec}, 32'h910);
        checkEq("sd_retired_cnt", {24'b0, instr_count}, 32'h3);
        step(0, BEQ_OP, 0, 1);
        step(0, 7'd0, 1, 1);
        checkEq("beq_taken_ctrl", {20'b0, ctrlVec}, 32'hC05);
        step(0, 7'd0, 0, 1);
        step(0, BEQ_OP, 0, 1);
        step(0, 7'd0, 0, 1);
        checkEq("beq_not_taken_ctrl", {20'b0, ctrlVec}, 32'h405);
        step(0, 7'd0, 0, 0);
        checkEq("beq_retired_cnt", {24'b0, instr_count}, 32'h5);

        // Illegal opcode traps until reset.
        step(0, 7'd0, 0, 1);
        step(0, 7'h7F, 0, 1);
        step(0, 7'd0, 1, 1);
        checkEq("illegal_set", {31'b0, Illegal}, 32'h1);
        checkEq("trap_ctrl", {20'b0, ctrlVec}, 32'h0);
        for (int i = 0; i < 5; i++) step(0, opcs[i % 4], 1'($urandom), 1'($urandom));
        step(1, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);
        checkEq("illegal_cleared", {31'b0, Illegal}, 32'h0);

        // Data read never completes: memory-error trap after TIMEOUT waits.
        step(0, 7'd0, 0, 1);
        step(0, LD_OP, 0, 1);
        step(0, 7'd0, 0, 1);
        for (int i = 0; i < TIMEOUT; i++) step(0, 7'd0, 0, 0);
        step(0, 7'd0, 0, 1);
        checkEq("memerr_set", {31'b0, MemErr}, 32'h1);
        checkEq("memerr_trap_ctrl", {20'b0, ctrlVec}, 32'h0);
        step(1, 7'd0, 0, 0);
        step(0, 7'd0, 0, 1);

        // Ready on the last allowed wait cycle still completes.
        step(0, 7'd0, 0, 1);
        step(0, LD_OP, 0, 1);
        step(0, 7'd0, 0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 7'd0, 0, 0);
        step(0, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);
        checkEq("late_ready_wb_ld", {20'b0, ctrlVec}, 32'h060);
        checkEq("late_ready_no_err", {31'b0, MemErr}, 32'h0);

        // Reset during a store wait aborts the write.
        step(0, 7'd0, 0, 1);
        step(0, SD_OP, 0, 1);
        step(0, 7'd0, 0, 1);
        step(0, 7'd0, 0, 0);
        checkEq("mem_wr_pending", {31'b0, MemWrite}, 32'h1);
        step(1, 7'd0, 0, 1);
        checkEq("rst_abort_write", {31'b0, MemWrite}, 32'h0);
        step(0, 7'd0, 0, 1);
        checkEq("rst_next_write", {31'b0, MemWrite}, 32'h0);
        checkEq("rst_abort_cnt", {24'b0, instr_count}, 32'h0);

        // Random traffic; a slow-memory stretch provokes timeouts.
        for (int cyc = 0; cyc < 6000; cyc++) begin
            logic       r;
            logic [6:0] o;
            readyPct = (cyc >= 3000 && cyc < 3400) ? 5 : 70;
            if (q.size() > 0 && q[0] == S_TRAP) r = ($urandom_range(0, 9) == 0);
            else r = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 39) == 0) o = 7'($urandom);
            else o = opcs[$urandom_range(0, 3)];
            step(r, o, 1'($urandom), ($urandom_range(0, 99) < readyPct));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
